// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a WB-to-operand bypass.
// Latency: 1 cycle from ID inputs to IDEX_*. stall_if_id is combinational in the same cycle.
// Backpressure: hold freezes every register; a load-use hazard inserts one bubble and raises stall_if_id.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   id_*               decoded instruction from ID: valid, pc, indices, operands, imm, funct, control
//   wb_RegWrite/rd/data  same-cycle register-file write from WB, bypassed into the captured operands
//   hold               global freeze; all state retains its value
//   flush              branch taken in EX; the ID instruction is replaced by a bubble
//   IDEX_*             registered fields consumed by the EX forwarding unit and ALU
//   stall_if_id        freeze PC and IF/ID this cycle (load-use hazard)
//   bubble_count       saturating count of load-use bubbles
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_funct,
    input  logic              id_RegWrite,
    input  logic              id_MemtoReg,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_Branch,
    input  logic [1:0]        id_ALUOp,

    input  logic              wb_RegWrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,

    input  logic              hold,
    input  logic              flush,

    output logic              IDEX_valid,
    output logic [DATA_W-1:0] IDEX_pc,
    output logic [DATA_W-1:0] IDEX_rdata1,
    output logic [DATA_W-1:0] IDEX_rdata2,
    output logic [DATA_W-1:0] IDEX_imm,
    output logic [REG_W-1:0]  IDEX_rs1,
    output logic [REG_W-1:0]  IDEX_rs2,
    output logic [REG_W-1:0]  IDEX_rd,
    output logic [3:0]        IDEX_funct,
    output logic              IDEX_RegWrite,
    output logic              IDEX_MemtoReg,
    output logic              IDEX_MemRead,
    output logic              IDEX_MemWrite,
    output logic              IDEX_ALUSrc,
    output logic              IDEX_Branch,
    output logic [1:0]        IDEX_ALUOp,

    output logic              stall_if_id,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Everything the stage registers. An all-zero value is a bubble.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [3:0]        funct;
        ctrl_t             ctrl;
    } idex_t;

    idex_t idex_q;
    idex_t capture;
    ctrl_t id_ctrl;
    logic  byp1;
    logic  byp2;
    logic  hazard;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Load in EX whose destination is read by the instruction in ID.
    // x0 loads never create a dependency.
    always_comb begin
        hazard = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rd != '0) && id_valid &&
                 ((id_use_rs1 && (idex_q.rd == id_rs1)) ||
                  (id_use_rs2 && (idex_q.rd == id_rs2)));
    end

    // A flushed instruction is wrong-path, so it must not stall the front end.
    assign stall_if_id = hazard && !flush && !reset;

    // The register file writes at the end of this cycle, so its read port
    // still shows the old value; take WB's value directly instead.
    assign byp1 = wb_RegWrite && (wb_rd != '0) && (wb_rd == id_rs1);
    assign byp2 = wb_RegWrite && (wb_rd != '0) && (wb_rd == id_rs2);

    always_comb begin
        id_ctrl            = '0;
        id_ctrl.reg_write  = id_RegWrite;
        id_ctrl.mem_to_reg = id_MemtoReg;
        id_ctrl.mem_read   = id_MemRead;
        id_ctrl.mem_write  = id_MemWrite;
        id_ctrl.alu_src    = id_ALUSrc;
        id_ctrl.branch     = id_Branch;
        id_ctrl.alu_op     = id_ALUOp;
    end

    always_comb begin
        capture        = '0;
        capture.valid  = id_valid;
        capture.pc     = id_pc;
        capture.rdata1 = byp1 ? wb_data : id_rdata1;
        capture.rdata2 = byp2 ? wb_data : id_rdata2;
        capture.imm    = id_imm;
        capture.rs1    = id_rs1;
        capture.rs2    = id_rs2;
        capture.rd     = id_rd;
        capture.funct  = id_funct;
        // An empty ID slot carries its data through but must not act.
        capture.ctrl   = id_valid ? id_ctrl : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q       <= '0;
            bubble_count <= '0;
        end else if (!hold) begin
            if (flush) begin
                idex_q <= '0;
            end else if (hazard) begin
                idex_q <= '0;
                if (bubble_count != CNT_MAX) begin
                    bubble_count <= bubble_count + CNT_ONE;
                end
            end else begin
                idex_q <= capture;
            end
        end
    end

    assign IDEX_valid    = idex_q.valid;
    assign IDEX_pc       = idex_q.pc;
    assign IDEX_rdata1   = idex_q.rdata1;
    assign IDEX_rdata2   = idex_q.rdata2;
    assign IDEX_imm      = idex_q.imm;
    assign IDEX_rs1      = idex_q.rs1;
    assign IDEX_rs2      = idex_q.rs2;
    assign IDEX_rd       = idex_q.rd;
    assign IDEX_funct    = idex_q.funct;
    assign IDEX_RegWrite = idex_q.ctrl.reg_write;
    assign IDEX_MemtoReg = idex_q.ctrl.mem_to_reg;
    assign IDEX_MemRead  = idex_q.ctrl.mem_read;
    assign IDEX_MemWrite = idex_q.ctrl.mem_write;
    assign IDEX_ALUSrc   = idex_q.ctrl.alu_src;
    assign IDEX_Branch   = idex_q.ctrl.branch;
    assign IDEX_ALUOp    = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm;
    logic [3:0]        id_funct;
    logic              id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc, id_Branch;
    logic [1:0]        id_ALUOp;
    logic              wb_RegWrite;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              hold, flush;
    logic              IDEX_valid;
    logic [DATA_W-1:0] IDEX_pc, IDEX_rdata1, IDEX_rdata2, IDEX_imm;
    logic [REG_W-1:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [3:0]        IDEX_funct;
    logic              IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc, IDEX_Branch;
    logic [1:0]        IDEX_ALUOp;
    logic              stall_if_id;
    logic [CNT_W-1:0]  bubble_count;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_funct(id_funct),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .hold(hold), .flush(flush),
        .IDEX_valid(IDEX_valid), .IDEX_pc(IDEX_pc), .IDEX_rdata1(IDEX_rdata1), .IDEX_rdata2(IDEX_rdata2),
        .IDEX_imm(IDEX_imm), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_funct(IDEX_funct), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemtoReg(IDEX_MemtoReg),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
        .IDEX_Branch(IDEX_Branch), .IDEX_ALUOp(IDEX_ALUOp),
        .stall_if_id(stall_if_id), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // One stimulus row: inputs, then the expected stall in that cycle and the
    // expected IDEX_* after the following edge. imm is driven equal to pc and
    // funct to pc[3:0]; ALUSrc/Branch follow rw, MemtoReg follows mr,
    // MemWrite = rw & ~mr, ALUOp = {rw,0}.
    typedef struct packed {
        logic             rst, hold, flush, vld;
        logic [4:0]       rs1, rs2, rd;
        logic             u1, u2, mr, rw;
        logic [63:0]      r1, r2;
        logic             wbw;
        logic [4:0]       wbrd;
        logic [63:0]      wbd;
        logic [63:0]      pc;
        logic             e_stall, e_vld;
        logic [4:0]       e_rs1, e_rs2, e_rd;
        logic             e_mr, e_rw;
        logic [63:0]      e_r1, e_r2;
        logic [3:0]       e_cnt;
        logic [63:0]      e_pc;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];
    vec_t sb [$];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset       = v.rst;
        hold        = v.hold;
        flush       = v.flush;
        id_valid    = v.vld;
        id_pc       = v.pc;
        id_imm      = v.pc;
        id_funct    = v.pc[3:0];
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_rd       = v.rd;
        id_use_rs1  = v.u1;
        id_use_rs2  = v.u2;
        id_rdata1   = v.r1;
        id_rdata2   = v.r2;
        id_RegWrite = v.rw;
        id_MemtoReg = v.mr;
        id_MemRead  = v.mr;
        id_MemWrite = v.rw & ~v.mr;
        id_ALUSrc   = v.rw;
        id_Branch   = v.rw;
        id_ALUOp    = {v.rw, 1'b0};
        wb_RegWrite = v.wbw;
        wb_rd       = v.wbrd;
        wb_data     = v.wbd;
    endtask

    task automatic compare_idex(input vec_t e, input int idx);
        logic [3:0] pc_lo;
        pc_lo = e.e_pc[3:0];
        chk("IDEX_valid",    idx, 64'(IDEX_valid),    64'(e.e_vld));
        chk("IDEX_rs1",      idx, 64'(IDEX_rs1),      64'(e.e_rs1));
        chk("IDEX_rs2",      idx, 64'(IDEX_rs2),      64'(e.e_rs2));
        chk("IDEX_rd",       idx, 64'(IDEX_rd),       64'(e.e_rd));
        chk("IDEX_rdata1",   idx, IDEX_rdata1,        e.e_r1);
        chk("IDEX_rdata2",   idx, IDEX_rdata2,        e.e_r2);
        chk("IDEX_pc",       idx, IDEX_pc,            e.e_pc);
        chk("IDEX_imm",      idx, IDEX_imm,           e.e_pc);
        chk("IDEX_funct",    idx, 64'(IDEX_funct),    64'(pc_lo));
        chk("IDEX_MemRead",  idx, 64'(IDEX_MemRead),  64'(e.e_mr));
        chk("IDEX_MemtoReg", idx, 64'(IDEX_MemtoReg), 64'(e.e_mr));
        chk("IDEX_RegWrite", idx, 64'(IDEX_RegWrite), 64'(e.e_rw));
        chk("IDEX_ALUSrc",   idx, 64'(IDEX_ALUSrc),   64'(e.e_rw));
        chk("IDEX_Branch",   idx, 64'(IDEX_Branch),   64'(e.e_rw));
        chk("IDEX_MemWrite", idx, 64'(IDEX_MemWrite), 64'(e.e_rw & ~e.e_mr));
        chk("IDEX_ALUOp",    idx, 64'(IDEX_ALUOp),    64'({e.e_rw, 1'b0}));
        chk("bubble_count",  idx, 64'(bubble_count),  64'(e.e_cnt));
    endtask

    initial begin
        vec_t v, e;
        reset = 1'b1;
        hold = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc = '0; id_imm = '0; id_funct = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rdata1 = '0; id_rdata2 = '0; id_RegWrite = 1'b0; id_MemtoReg = 1'b0; id_MemRead = 1'b0;
        id_MemWrite = 1'b0; id_ALUSrc = 1'b0; id_Branch = 1'b0; id_ALUOp = '0;
        wb_RegWrite = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset for two cycles under random inputs.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            v = '0;
            v.rst = 1'b1; v.hold = 1'($urandom); v.flush = 1'($urandom); v.vld = 1'b1;
            v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.rd = 5'($urandom);
            v.u1 = 1'b1; v.u2 = 1'b1; v.mr = 1'($urandom); v.rw = 1'b1;
            v.r1 = {$urandom, $urandom}; v.r2 = {$urandom, $urandom};
            v.wbw = 1'b1; v.wbrd = 5'($urandom); v.wbd = {$urandom, $urandom}; v.pc = {$urandom, $urandom};
            drive(v);
            #1 chk("reset_stall", c, 64'(stall_if_id), 64'd0);
            e = '0;
            sb.push_back(e);
            @(posedge clk);
            #1 e = sb.pop_front();
            compare_idex(e, c);
        end

        //          rst hold fl vld rs1 rs2 rd  u1 u2 mr rw r1      r2      wbw wbrd wbd     pc        | st vld rs1 rs2 rd mr rw e_r1    e_r2    cnt e_pc
        tbl[0]  = '{0, 0, 0, 1, 1, 2, 3,   1, 1, 0, 1, 5,      7,      0, 0, 0,       'h100,    0, 1, 1, 2, 3,  0, 1, 5,      7,      0, 'h100};
        tbl[1]  = '{0, 0, 0, 1, 1, 0, 5,   1, 0, 1, 1, 'h20,   0,      0, 0, 0,       'h104,    0, 1, 1, 0, 5,  1, 1, 'h20,   0,      0, 'h104};
        tbl[2]  = '{0, 0, 0, 1, 5, 1, 6,   1, 1, 0, 1, 'hAA,   'hBB,   0, 0, 0,       'h108,    1, 0, 0, 0, 0,  0, 0, 0,      0,      1, 0};
        tbl[3]  = '{0, 0, 0, 1, 5, 1, 6,   1, 1, 0, 1, 'hAA,   'hBB,   0, 0, 0,       'h108,    0, 1, 5, 1, 6,  0, 1, 'hAA,   'hBB,   1, 'h108};
        tbl[4]  = '{0, 0, 0, 1, 1, 0, 0,   1, 0, 1, 1, 'h30,   0,      0, 0, 0,       'h10c,    0, 1, 1, 0, 0,  1, 1, 'h30,   0,      1, 'h10c};
        tbl[5]  = '{0, 0, 0, 1, 0, 0, 7,   1, 1, 0, 1, 0,      0,      0, 0, 0,       'h110,    0, 1, 0, 0, 7,  0, 1, 0,      0,      1, 'h110};
        tbl[6]  = '{0, 0, 0, 1, 2, 0, 5,   1, 0, 1, 1, 'h40,   0,      0, 0, 0,       'h114,    0, 1, 2, 0, 5,  1, 1, 'h40,   0,      1, 'h114};
        tbl[7]  = '{0, 0, 0, 1, 9, 5, 8,   1, 0, 0, 1, 'h50,   'h60,   0, 0, 0,       'h118,    0, 1, 9, 5, 8,  0, 1, 'h50,   'h60,   1, 'h118};
        tbl[8]  = '{0, 0, 0, 1, 4, 3, 9,   1, 1, 0, 1, 'h11,   'h22,   1, 4, 'h99,    'h11c,    0, 1, 4, 3, 9,  0, 1, 'h99,   'h22,   1, 'h11c};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 10,  1, 1, 0, 1, 'h11,   'h22,   1, 0, 'h99,    'h120,    0, 1, 0, 0, 10, 0, 1, 'h11,   'h22,   1, 'h120};
        tbl[10] = '{0, 0, 0, 1, 6, 6, 11,  1, 1, 0, 1, 1,      2,      1, 6, 'h77,    'h124,    0, 1, 6, 6, 11, 0, 1, 'h77,   'h77,   1, 'h124};
        tbl[11] = '{0, 0, 0, 1, 6, 6, 12,  1, 1, 0, 1, 3,      4,      0, 6, 'h77,    'h128,    0, 1, 6, 6, 12, 0, 1, 3,      4,      1, 'h128};
        tbl[12] = '{0, 0, 0, 1, 1, 0, 5,   1, 0, 1, 1, 'h10,   0,      0, 0, 0,       'h12c,    0, 1, 1, 0, 5,  1, 1, 'h10,   0,      1, 'h12c};
        tbl[13] = '{0, 0, 1, 1, 5, 1, 6,   1, 1, 0, 1, 'hAA,   'hBB,   0, 0, 0,       'h130,    0, 0, 0, 0, 0,  0, 0, 0,      0,      1, 0};
        tbl[14] = '{0, 0, 0, 1, 1, 0, 5,   1, 0, 1, 1, 'h55,   0,      0, 0, 0,       'h134,    0, 1, 1, 0, 5,  1, 1, 'h55,   0,      1, 'h134};
        tbl[15] = '{0, 1, 0, 1, 5, 1, 6,   1, 1, 0, 1, 'hAA,   'hBB,   0, 0, 0,       'h138,    1, 1, 1, 0, 5,  1, 1, 'h55,   0,      1, 'h134};
        for (int k = 16; k <= 18; k++) begin
            tbl[k] = tbl[15];
            tbl[k].flush = 1'b1;
            tbl[k].e_stall = 1'b0;
        end
        tbl[19] = '{0, 0, 1, 1, 5, 1, 6,   1, 1, 0, 1, 'hAA,   'hBB,   0, 0, 0,       'h138,    0, 0, 0, 0, 0,  0, 0, 0,      0,      1, 0};
        tbl[20] = '{0, 0, 0, 1, 5, 1, 6,   1, 1, 0, 1, 'hAA,   'hBB,   0, 0, 0,       'h138,    0, 1, 5, 1, 6,  0, 1, 'hAA,   'hBB,   1, 'h138};
        tbl[21] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 5,      6,      0, 0, 0,       'h13c,    0, 0, 0, 0, 0,  0, 0, 5,      6,      1, 'h13c};
        tbl[22] = '{0, 0, 0, 1, 1, 0, 5,   1, 0, 1, 1, 'h66,   0,      0, 0, 0,       'h140,    0, 1, 1, 0, 5,  1, 1, 'h66,   0,      1, 'h140};
        tbl[23] = '{1, 0, 0, 1, 5, 1, 6,   1, 1, 0, 1, 'hAA,   'hBB,   0, 0, 0,       'h144,    0, 0, 0, 0, 0,  0, 0, 0,      0,      0, 0};
        tbl[24] = '{0, 0, 0, 1, 1, 2, 3,   1, 1, 0, 1, 5,      7,      0, 0, 0,       'h148,    0, 1, 1, 2, 3,  0, 1, 5,      7,      0, 'h148};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1 chk("stall_if_id", i, 64'(stall_if_id), 64'(tbl[i].e_stall));
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1 e = sb.pop_front();
            compare_idex(e, i);
        end

        // Saturation: 20 load-use pairs; each inserts exactly one bubble.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            v = '0;
            v.vld = 1'b1; v.rs1 = 5'd1; v.rd = 5'd5; v.u1 = 1'b1; v.mr = 1'b1; v.rw = 1'b1; v.pc = 64'h200;
            drive(v);
            @(negedge clk);
            v = '0;
            v.vld = 1'b1; v.rs1 = 5'd5; v.rs2 = 5'd1; v.rd = 5'd6; v.u1 = 1'b1; v.u2 = 1'b1; v.rw = 1'b1; v.pc = 64'h204;
            drive(v);
            #1 chk("sat_stall", k, 64'(stall_if_id), 64'd1);
            @(posedge clk);
            #1 chk("sat_count", k, 64'(bubble_count), 64'((k > 15) ? 15 : k));
            chk("sat_bubble_valid", k, 64'(IDEX_valid), 64'd0);
            @(negedge clk);
            #1 chk("sat_release", k, 64'(stall_if_id), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with the load-use hazard detector.
- Captures decoded operands and control from ID and presents the IDEX_* fields consumed by the EX-stage forwarding unit and ALU.
- Inserts bubbles on load-use hazards and branch flushes.
- Bypasses same-cycle WB writes into the captured operands, because the forwarding unit only covers EX/MEM and MEM/WB.

Parameters:
DATA_W, 64, operand/immediate/PC width
REG_W, 5, register index width
CNT_W, 16, bubble performance counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_W  instruction PC
id_rs1, id_rs2, id_rd  in  REG_W  register indices
id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
id_rdata1, id_rdata2  in  DATA_W  register file read data
id_imm  in  DATA_W  sign-extended immediate
id_funct  in  4  {funct7[5], funct3}
id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc, id_Branch  in  1  control
id_ALUOp  in  2  ALU op class
wb_RegWrite  in  1  WB-stage write enable
wb_rd  in  REG_W  WB destination
wb_data  in  DATA_W  WB write data
hold  in  1  global freeze (memory stall)
flush  in  1  branch taken in EX, kill ID instruction
IDEX_valid  out  1  EX holds a real instruction
IDEX_pc, IDEX_rdata1, IDEX_rdata2, IDEX_imm  out  DATA_W  registered fields
IDEX_rs1, IDEX_rs2, IDEX_rd  out  REG_W  registered indices
IDEX_funct  out  4  registered funct
IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc, IDEX_Branch  out  1  registered control
IDEX_ALUOp  out  2  registered ALU op
stall_if_id  out  1  combinational: freeze PC and IF/ID this cycle
bubble_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- All IDEX_* outputs are registers. Latency from ID inputs to IDEX_* is 1 cycle.
- Reset:
  - All IDEX_* outputs and bubble_count go to 0 on the next edge.
  - stall_if_id is 0 while reset is high.
  - Reset mid-operation discards the in-flight instruction.
- Hazard detection (combinational):
  - hazard = IDEX_valid & IDEX_MemRead & (IDEX_rd!=0) & id_valid & ((id_use_rs1 & IDEX_rd==id_rs1) | (id_use_rs2 & IDEX_rd==id_rs2)).
  - stall_if_id = hazard & ~flush & ~reset.
  - hold does not mask stall_if_id.
- Edge priority, highest first:
  - 1. reset: clear all state.
  - 2. hold: every register retains its value. A flush or hazard in this cycle has no effect; upstream keeps flush asserted until hold drops.
  - 3. flush: load a bubble.
  - 4. hazard: load a bubble and increment bubble_count. The counter saturates at all-ones and does not wrap.
  - 5. otherwise: capture the ID inputs. IDEX_valid = id_valid.
- Bubble contents:
  - IDEX_valid and all control outputs (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp) are 0.
  - Indices rs1, rs2 and rd are 0, so the forwarding unit never matches a bubble.
  - Data fields (pc, rdata1, rdata2, imm, funct) are 0.
- Capture with id_valid=0: control is forced to 0 exactly as in a bubble. Data is captured as presented.
- WB bypass on capture only:
  - IDEX_rdata1 = (wb_RegWrite & wb_rd!=0 & wb_rd==id_rs1) ? wb_data : id_rdata1. IDEX_rdata2 is handled the same way.
  - x0 is never bypassed.
  - The bypass also applies when the same index is used for both rs1 and rs2.
- Flush and hazard in the same cycle: flush wins. stall_if_id=0 and bubble_count is unchanged, since the wrong-path instruction is discarded.
- Hazard persists for exactly one cycle per load-use pair. After the bubble, IDEX_MemRead=0, so hazard drops and the stalled instruction captures normally.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> all IDEX_*=0, bubble_count=0, stall_if_id=0. Deassert, present add x3,x1,x2 with rdata1=5, rdata2=7 -> next cycle IDEX_rs1=1, IDEX_rs2=2, IDEX_rd=3, IDEX_rdata1=5, IDEX_rdata2=7, IDEX_valid=1.
- Load-use: ld x5 captured (MemRead=1, rd=5), then ID add x6,x5,x1 -> stall_if_id=1 that cycle. Next IDEX is a bubble (valid=0, RegWrite=0, rd=0) and bubble_count=1. Following cycle the add captures with stall_if_id=0.
- No false hazard: ld x0 followed by use of x0 -> stall_if_id=0. ld x5 followed by an instruction with id_use_rs2=0, id_rs2=5 -> stall_if_id=0.
- WB bypass: id_rs1=4, id_rdata1=0x11, wb_RegWrite=1, wb_rd=4, wb_data=0x99 -> IDEX_rdata1=0x99. Same with wb_rd=0, id_rs1=0 -> IDEX_rdata1=id_rdata1.
- Flush vs hazard vs hold:
  - Flush and hazard together -> bubble, stall_if_id=0, bubble_count unchanged.
  - hold=1 for 3 cycles with flush=1 -> IDEX_* unchanged throughout.
  - Drop hold with flush=1 -> bubble.
- Counter saturation (CNT_W=4 build): 20 consecutive load-use pairs -> bubble_count stops at 15.
